// File: rtl/eggtimer_pkg.sv
// Shared egg-timer definitions: FSM state encoding, BCD limits, load sanitiser.
package eggtimer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StAlarm = 2'd3
  } state_e;

  localparam logic [3:0] BcdDigitMax   = 4'd9;
  localparam logic [3:0] BcdSecTensMax = 4'd5;

  localparam int unsigned DefaultTicksPerSec = 10;

  // Clamp a {tens, ones} BCD byte: ones to 9, tens to tens_max.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v, input logic [3:0] tens_max);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = (v[7:4] > tens_max)    ? tens_max    : v[7:4];
    ones = (v[3:0] > BcdDigitMax) ? BcdDigitMax : v[3:0];
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational MM:SS BCD decrement by one second. 00:00 passes through unchanged.
module bcd_time_dec
  import eggtimer_pkg::*;
(
  input  logic [15:0] time_in,
  output logic [15:0] time_out,
  output logic        zero
);

  logic [3:0] mt, mo, st, so;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic       in_zero;

  assign mt      = time_in[15:12];
  assign mo      = time_in[11:8];
  assign st      = time_in[7:4];
  assign so      = time_in[3:0];
  assign in_zero = (time_in == 16'h0000);

  // Ripple the borrow from seconds-ones up to minutes-tens.
  always_comb begin
    mt_d = mt;
    mo_d = mo;
    st_d = st;
    so_d = so;
    if (!in_zero) begin
      if (so != 4'd0) begin
        so_d = so - 4'd1;
      end else begin
        so_d = BcdDigitMax;
        if (st != 4'd0) begin
          st_d = st - 4'd1;
        end else begin
          st_d = BcdSecTensMax;
          if (mo != 4'd0) begin
            mo_d = mo - 4'd1;
          end else begin
            mo_d = BcdDigitMax;
            mt_d = mt - 4'd1;
          end
        end
      end
    end
  end

  assign time_out = {mt_d, mo_d, st_d, so_d};
  // Flags a result of 00:00, i.e. the decrement that should fire the alarm.
  assign zero     = (time_out == 16'h0000);

endmodule

// File: rtl/countdown_timer.sv
// Egg-timer core: BCD MM:SS countdown driven by divider ticks, with timed alarm.
module countdown_timer
  import eggtimer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DefaultTicksPerSec,
  parameter int unsigned ALARM_SECS    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start_stop,
  input  logic       clear,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  localparam int unsigned SubW       = $clog2(TICKS_PER_SEC);
  localparam int unsigned AlarmTicks = ALARM_SECS * TICKS_PER_SEC;
  localparam int unsigned AlarmW     = $clog2(AlarmTicks);

  localparam logic [SubW-1:0]   SubLast   = SubW'(TICKS_PER_SEC - 1);
  localparam logic [AlarmW-1:0] AlarmLast = AlarmW'(AlarmTicks - 1);

  state_e            state_q;
  logic [SubW-1:0]   sub_q;
  logic [AlarmW-1:0] acnt_q;

  logic [15:0] load_time;
  logic [15:0] dec_time;
  logic        dec_zero;
  logic        time_zero;
  logic        sec_done;

  // Sanitise the load value so the held time is always valid BCD MM:SS.
  always_comb begin
    load_time = {clamp_bcd(load_mm, BcdDigitMax), clamp_bcd(load_ss, BcdSecTensMax)};
  end

  assign time_zero = ({mm, ss} == 16'h0000);
  assign sec_done  = tick && (sub_q == SubLast);

  bcd_time_dec u_dec (
    .time_in  ({mm, ss}),
    .time_out (dec_time),
    .zero     (dec_zero)
  );

  // Timer FSM with registered outputs, sub-second counter and alarm counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mm      <= 8'h00;
      ss      <= 8'h00;
      running <= 1'b0;
      alarm   <= 1'b0;
      done    <= 1'b0;
      sub_q   <= '0;
      acnt_q  <= '0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state_q <= StIdle;
        mm      <= 8'h00;
        ss      <= 8'h00;
        running <= 1'b0;
        alarm   <= 1'b0;
        sub_q   <= '0;
        acnt_q  <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            // load wins over a coincident start_stop
            if (load) begin
              {mm, ss} <= load_time;
            end else if (start_stop && !time_zero) begin
              state_q <= StRun;
              running <= 1'b1;
              sub_q   <= '0;
            end
          end

          StRun: begin
            // The tick is applied before start_stop; reaching 00:00 drops start_stop.
            if (sec_done && !time_zero) begin
              sub_q    <= '0;
              {mm, ss} <= dec_time;
              if (dec_zero) begin
                state_q <= StAlarm;
                running <= 1'b0;
                alarm   <= 1'b1;
                done    <= 1'b1;
                acnt_q  <= '0;
              end else if (start_stop) begin
                state_q <= StPause;
                running <= 1'b0;
              end
            end else begin
              if (tick) begin
                sub_q <= sub_q + SubW'(1);
              end
              if (start_stop) begin
                state_q <= StPause;
                running <= 1'b0;
              end
            end
          end

          StPause: begin
            if (load) begin
              {mm, ss} <= load_time;
              sub_q    <= '0;
              state_q  <= StIdle;
            end else if (start_stop) begin
              state_q <= StRun;
              running <= 1'b1;
            end
          end

          StAlarm: begin
            if (start_stop) begin
              state_q <= StIdle;
              alarm   <= 1'b0;
              acnt_q  <= '0;
            end else if (tick) begin
              if (acnt_q == AlarmLast) begin
                state_q <= StIdle;
                alarm   <= 1'b0;
                acnt_q  <= '0;
              end else begin
                acnt_q <= acnt_q + AlarmW'(1);
              end
            end
          end

          default: begin
            state_q <= StIdle;
            running <= 1'b0;
            alarm   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
